spike_rate_encoder: RTL and testbench
=====================================

// Module: spike_rate_encoder
// PURPOSE
//  Input-side companion to the LIF neuron layer. Converts a frame of NUM_CH unsigned
//  intensities into per-channel spike trains, one bit per channel per timestep.
//  The bits drive the 1-bit current inputs of the LIF network.
//  Coding is deterministic (accumulator overflow). Over a window of WINDOW steps, a
//  channel of intensity I emits exactly floor(I*WINDOW / 2^DATA_W) spikes.
// PARAMETERS
//  NUM_CH  8   number of channels (one per first-layer LIF neuron)
//  DATA_W  8   intensity width per channel, unsigned
//  WINDOW  16  timesteps per frame, >=2; step counter width = $clog2(WINDOW)
// PORTS
//  clk          in   1              clock, all state on rising edge
//  rst_n        in   1              reset, asynchronous, active-low
//  in_valid     in   1              frame intensities present on in_data
//  in_ready     out  1              encoder can accept a frame
//  in_data      in   NUM_CH*DATA_W  channel c at [c*DATA_W +: DATA_W]
//  step_en      in   1              advance one timestep this cycle (network tick)
//  spike_out    out  NUM_CH         spike bits of the current step; to LIF current inputs
//  spike_valid  out  1              spike_out holds a valid step this cycle
//  frame_done   out  1              1-cycle pulse, coincides with the last step of a frame
//  busy         out  1              frame in progress (state RUN)
// BEHAVIOUR
//  - Reset values (async, rst_n=0): state IDLE, acc[c]=0, int_q[c]=0, step=0,
//    spike_out=0, spike_valid=0, frame_done=0, busy=0.
//  - in_ready = (state==IDLE), combinational. in_ready is 1 out of reset.
//  - FSM states: IDLE, RUN.
//  - IDLE -> RUN on in_valid&&in_ready. On that edge: latch int_q <= in_data, clear
//    acc to 0, clear step to 0. No spike is produced in the accept cycle.
//  - RUN, step_en=1, per channel: sum = {1'b0,acc}+{1'b0,int_q} (DATA_W+1 bits).
//    Registered updates: spike_out[c] <= sum[DATA_W]; acc <= sum[DATA_W-1:0];
//    spike_valid <= 1; step <= step+1.
//  - RUN, step_en=0: acc and step hold. spike_valid <= 0 and spike_out <= 0.
//    Outputs are zero whenever no step is emitted.
//  - Last step: the step taken with step==WINDOW-1 also sets frame_done <= 1 and
//    returns state to IDLE. The next frame can be accepted in the cycle after
//    frame_done is high, so frames can run back to back with one idle cycle between them.
//  - Latency: the first spike_valid comes >=2 cycles after acceptance (accept edge, then
//    first step edge). A frame with step_en tied high lasts exactly WINDOW cycles of
//    spike_valid.
//  - in_valid while busy is ignored and the data is not captured. Upstream must hold
//    in_valid and in_data until in_ready.
//  - Boundaries: I=0 gives no spikes. I=2^DATA_W-1 gives WINDOW-1 spikes, with none at
//    step 0. step wraps only through the RUN->IDLE transition and never exceeds WINDOW-1.
//  - Reset asserted mid-frame aborts immediately: all outputs go to 0 asynchronously,
//    and after release the block is IDLE with in_ready=1.
// STRUCTURE
//  - Shared package lif_pkg: enc_state_t enum {ENC_IDLE, ENC_RUN}, default
//    SPIKE_DATA_W=8, SPIKE_WINDOW=16.
//  - One sub-module, spike_enc_channel: holds one acc register and one int_q register.
//    Ports: clk, rst_n, load, step, intensity, spike. It is instantiated NUM_CH times
//    in a generate loop.
//  - The top level holds the FSM, the step counter and the output registers.
// TESTING
//  1 Reset, then step_en=1, in_data all channels 8'd128, in_valid 1 cycle ->
//    16 spike_valid cycles, each channel spikes at steps 1,3,...,15 (8 spikes).
//    frame_done on step 15.
//  2 Channels = {0,16,64,255,1,32,200,128} -> per-channel spike counts
//    {0,1,4,15,0,2,12,8}. ch1 spikes only at step 15.
//  3 step_en toggling 1,0,1,0 during a frame of 128s -> spike_valid only on
//    step_en-high edges, outputs 0 otherwise. Totals same as scenario 1.
//  4 in_valid held high with new data during RUN -> data is not captured and the
//    running counts are unchanged. The second frame is accepted the cycle after
//    frame_done and produces its own counts.
//  5 rst_n pulsed low at step 7 of a frame -> spike_out, spike_valid, busy and
//    frame_done all drop to 0 immediately. in_ready=1 after release; the next frame
//    starts from acc=0.
//  6 Back-to-back frames 255 then 0 -> 15 spikes, then none. Exactly one frame_done
//    pulse per frame.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared types and defaults for the LIF input side: encoder FSM states and
// default intensity width / frame window.
package lif_pkg;

    typedef enum logic {
        ENC_IDLE = 1'b0,
        ENC_RUN  = 1'b1
    } enc_state_t;

    localparam int SPIKE_DATA_W = 8;
    localparam int SPIKE_WINDOW = 16;

endpackage

// File: rtl/spike_enc_channel.sv
// One rate-coding lane: a latched intensity added into an accumulator each step;
// the adder carry-out is the spike bit for that step.
module spike_enc_channel
    import lif_pkg::*;
#(
    parameter int DATA_W = SPIKE_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] intensity,
    output logic              spike
);

    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] int_q, int_d;
    logic [DATA_W:0]   sum;

    assign sum   = {1'b0, acc_q} + {1'b0, int_q};
    assign spike = sum[DATA_W];

    // Accumulator restarts from zero on every new frame so spike timing is
    // identical for identical intensities.
    always_comb begin
        acc_d = acc_q;
        int_d = int_q;
        if (load) begin
            int_d = intensity;
            acc_d = '0;
        end else if (step) begin
            acc_d = sum[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            int_q <= '0;
        end else begin
            acc_q <= acc_d;
            int_q <= int_d;
        end
    end

endmodule

// File: rtl/spike_rate_encoder.sv
// Frame-to-spike-train encoder: accepts NUM_CH intensities, then emits WINDOW
// timesteps of spike bits (one per step_en) from per-channel accumulators.
module spike_rate_encoder
    import lif_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int DATA_W = SPIKE_DATA_W,
    parameter int WINDOW = SPIKE_WINDOW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic                     step_en,
    output logic [NUM_CH-1:0]        spike_out,
    output logic                     spike_valid,
    output logic                     frame_done,
    output logic                     busy
);

    localparam int SW = $clog2(WINDOW);
    localparam logic [SW-1:0] LAST_STEP = SW'(WINDOW - 1);

    enc_state_t        state_q, state_d;
    logic [SW-1:0]     step_q, step_d;
    logic [NUM_CH-1:0] spike_out_q, spike_out_d;
    logic              spike_valid_q, spike_valid_d;
    logic              frame_done_q, frame_done_d;

    logic              accept;
    logic              adv;
    logic [NUM_CH-1:0] ch_spike;

    assign in_ready = (state_q == ENC_IDLE);
    assign busy     = (state_q == ENC_RUN);
    assign accept   = in_ready && in_valid;
    assign adv      = busy && step_en;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        spike_enc_channel #(
            .DATA_W(DATA_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (accept),
            .step     (adv),
            .intensity(in_data[g*DATA_W +: DATA_W]),
            .spike    (ch_spike[g])
        );
    end

    // Outputs default to zero so nothing leaks out on cycles without a step.
    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        spike_out_d   = '0;
        spike_valid_d = 1'b0;
        frame_done_d  = 1'b0;
        case (state_q)
            ENC_IDLE: begin
                if (in_valid) begin
                    state_d = ENC_RUN;
                    step_d  = '0;
                end
            end
            ENC_RUN: begin
                if (step_en) begin
                    spike_out_d   = ch_spike;
                    spike_valid_d = 1'b1;
                    if (step_q == LAST_STEP) begin
                        frame_done_d = 1'b1;
                        state_d      = ENC_IDLE;
                        step_d       = '0;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
            end
            default: state_d = ENC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ENC_IDLE;
            step_q        <= '0;
            spike_out_q   <= '0;
            spike_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            spike_out_q   <= spike_out_d;
            spike_valid_q <= spike_valid_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign spike_out   = spike_out_q;
    assign spike_valid = spike_valid_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder: per-frame spike counts, timing and reset abort.
module tb_spike_rate_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        step_en;
    logic [7:0]  spike_out;
    logic        spike_valid;
    logic        frame_done;
    logic        busy;

    spike_rate_encoder #(.NUM_CH(8), .DATA_W(8), .WINDOW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .step_en    (step_en),
        .spike_out  (spike_out),
        .spike_valid(spike_valid),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // per-frame capture filled by the monitor
    int fr_cnt [16][8];
    int fr_first [16][8];
    int fr_nv [16];
    int fr_last [16];
    int fr_done_cyc [16];
    int fr_fv_cyc [16];
    int nfr = 0;
    int viol = 0;
    int cyc = 0;
    int cur_cnt [8];
    int cur_first [8];
    int cur_nv = 0;
    int cur_fv = 0;
    logic se_edge = 1'b0;

    initial forever begin
        @(posedge clk);
        se_edge = step_en;
    end

    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            cur_nv = 0;
            for (int c = 0; c < 8; c++) begin
                cur_cnt[c] = 0;
                cur_first[c] = -1;
            end
        end else begin
            if (spike_valid) begin
                if (!se_edge) viol++;
                if (cur_nv == 0) cur_fv = cyc;
                for (int c = 0; c < 8; c++)
                    if (spike_out[c]) begin
                        cur_cnt[c]++;
                        if (cur_first[c] < 0) cur_first[c] = cur_nv;
                    end
                cur_nv++;
            end else if (spike_out != 8'h00) begin
                viol++;
            end
            if (frame_done) begin
                if (!spike_valid) viol++;
                if (nfr < 16) begin
                    for (int c = 0; c < 8; c++) begin
                        fr_cnt[nfr][c] = cur_cnt[c];
                        fr_first[nfr][c] = cur_first[c];
                    end
                    fr_nv[nfr] = cur_nv;
                    fr_last[nfr] = cur_nv - 1;
                    fr_done_cyc[nfr] = cyc;
                    fr_fv_cyc[nfr] = cur_fv;
                end
                nfr++;
                cur_nv = 0;
                for (int c = 0; c < 8; c++) begin
                    cur_cnt[c] = 0;
                    cur_first[c] = -1;
                end
            end
        end
    end

    // present a frame and return on the negedge after the accept edge
    task automatic start_frame(input logic [63:0] d);
        @(negedge clk);
        in_data = d;
        in_valid = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic wait_frames(input int n, input string tag);
        for (int k = 0; k < 200; k++) begin
            if (nfr >= n) break;
            @(negedge clk);
            #1;
        end
        chk(tag, int'(nfr >= n), 1);
    endtask

    task automatic chk_all(input int f, input int exp, input string tag);
        for (int c = 0; c < 8; c++) chk($sformatf("%s_ch%0d", tag, c), fr_cnt[f][c], exp);
    endtask

    localparam logic [63:0] ALL128 = {8{8'd128}};
    localparam logic [63:0] ALL64  = {8{8'd64}};
    localparam logic [63:0] ALL255 = {8{8'd255}};
    localparam logic [63:0] VEC2   = {8'd128, 8'd200, 8'd32, 8'd1, 8'd255, 8'd64, 8'd16, 8'd0};
    int exp2 [8] = '{0, 1, 4, 15, 0, 2, 12, 8};

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        step_en = 1'b0;
        #1;
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(spike_valid), 0);
        chk("rst_spike", int'(spike_out), 0);
        chk("rst_done", int'(frame_done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: all 128, step_en high
        step_en = 1'b1;
        start_frame(ALL128);
        in_valid = 1'b0;
        chk("s1_busy", int'(busy), 1);
        chk("s1_acc_novalid", int'(spike_valid), 0);
        chk("s1_acc_noready", int'(in_ready), 0);
        wait_frames(1, "s1_timeout");
        chk("s1_nvalid", fr_nv[0], 16);
        chk_all(0, 8, "s1_cnt");
        chk("s1_first", fr_first[0][0], 1);
        chk("s1_done_step", fr_last[0], 15);
        chk("s1_ready_after", int'(in_ready), 1);

        // 2: mixed intensities
        start_frame(VEC2);
        in_valid = 1'b0;
        wait_frames(2, "s2_timeout");
        for (int c = 0; c < 8; c++) chk($sformatf("s2_cnt_ch%0d", c), fr_cnt[1][c], exp2[c]);
        chk("s2_ch1_step", fr_first[1][1], 15);
        chk("s2_ch3_first", fr_first[1][3], 1);

        // 3: step_en toggling
        start_frame(ALL128);
        in_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (nfr >= 3) break;
            step_en = ~step_en;
            @(negedge clk);
            #1;
        end
        step_en = 1'b1;
        wait_frames(3, "s3_timeout");
        chk("s3_nvalid", fr_nv[2], 16);
        chk_all(2, 8, "s3_cnt");
        chk("s3_gating", viol, 0);

        // 4: in_valid held with new data while running
        start_frame(ALL128);
        in_data = ALL64;
        wait_frames(4, "s4_timeout1");
        @(negedge clk);
        in_valid = 1'b0;
        wait_frames(5, "s4_timeout2");
        chk_all(3, 8, "s4_f1_cnt");
        chk_all(4, 4, "s4_f2_cnt");
        chk("s4_gap", fr_fv_cyc[4] - fr_done_cyc[3], 2);

        // 5: reset mid-frame
        start_frame(ALL128);
        in_valid = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (cur_nv == 7) break;
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #2;
        chk("s5_pre_spike", int'(spike_out), 255);
        rst_n = 1'b0;
        #1;
        chk("s5_spike", int'(spike_out), 0);
        chk("s5_valid", int'(spike_valid), 0);
        chk("s5_busy", int'(busy), 0);
        chk("s5_done", int'(frame_done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("s5_ready", int'(in_ready), 1);
        chk("s5_nfr", nfr, 5);
        start_frame(ALL255);
        in_valid = 1'b0;
        wait_frames(6, "s5_timeout");
        chk_all(5, 15, "s5_cnt");
        chk("s5_first", fr_first[5][0], 1);

        // 6: back-to-back 255 then 0
        start_frame(ALL255);
        in_data = '0;
        wait_frames(7, "s6_timeout1");
        @(negedge clk);
        in_valid = 1'b0;
        wait_frames(8, "s6_timeout2");
        chk_all(6, 15, "s6_f1_cnt");
        chk_all(7, 0, "s6_f2_cnt");
        chk("s6_f1_nv", fr_nv[6], 16);
        chk("s6_f2_nv", fr_nv[7], 16);
        chk("s6_gap", fr_fv_cyc[7] - fr_done_cyc[6], 2);
        repeat (6) @(negedge clk);
        #1;
        chk("s6_one_done", nfr, 8);
        chk("viol", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
